// File: rtl/pushbutton_debounce.sv
// pushbutton_debounce: synchronises and debounces a raw push-button into a clean level,
// press/release strobes and a saturating bounce counter.
module pushbutton_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       button_raw,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] glitch_count
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {RELEASED, WAIT_PRESS, PRESSED, WAIT_RELEASE} state_e;
  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [7:0]             glitch_q, glitch_d, glitch_inc;
  logic                   level_q, level_d, press_q, press_d, release_q, release_d;
  logic                   s, term;
  assign s          = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
  assign term       = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
  assign glitch_inc = glitch_q + {7'd0, glitch_q != 8'hff};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= {SYNC_STAGES{ACTIVE_LOW}};
      state_q   <= RELEASED;
      cnt_q     <= '0;
      glitch_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], button_raw};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      glitch_q  <= glitch_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end
  // A bounce is checked before terminal count, so it always aborts the window.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    glitch_d = glitch_q;
    case (state_q)
      RELEASED: if (s) begin
        state_d = WAIT_PRESS;
        cnt_d   = '0;
      end
      WAIT_PRESS: if (!s) begin
        state_d  = RELEASED;
        cnt_d    = '0;
        glitch_d = glitch_inc;
      end else if (term) state_d = PRESSED;
      else cnt_d = CW'(cnt_q + 1'b1);
      PRESSED: if (!s) begin
        state_d = WAIT_RELEASE;
        cnt_d   = '0;
      end
      WAIT_RELEASE: if (s) begin
        state_d  = PRESSED;
        cnt_d    = '0;
        glitch_d = glitch_inc;
      end else if (term) state_d = RELEASED;
      else cnt_d = CW'(cnt_q + 1'b1);
      default: state_d = RELEASED;
    endcase
  end
  always_comb begin
    press_d   = state_q == WAIT_PRESS && s && term;
    release_d = state_q == WAIT_RELEASE && !s && term;
    level_d   = press_d ? 1'b1 : release_d ? 1'b0 : level_q;
  end
  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign glitch_count  = glitch_q;
endmodule

// File: tb/tb_pushbutton_debounce.sv
// tb_pushbutton_debounce: runs an active-low and an active-high instance on mirrored stimulus;
// expected strobes are queued with their due cycle and checked as the DUTs emit them.
module tb_pushbutton_debounce;
  localparam int DC = 4;
  localparam int SS = 2;
  localparam int LAT = SS + DC + 1;
  typedef struct {bit press; int at;} ev_t;
  logic       clk = 1'b0, reset_n = 1'b1, raw = 1'b1, raw_n;
  logic [1:0] lvl, pp, rp;
  logic [7:0] gc [2];
  int         cyc = 0, total = 0, bad = 0, exp_gc = 0;
  ev_t        exp_q[$];
  ev_t        e;
  assign raw_n = ~raw;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  pushbutton_debounce #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS), .ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .reset_n(reset_n), .button_raw(raw), .btn_level(lvl[0]),
    .press_pulse(pp[0]), .release_pulse(rp[0]), .glitch_count(gc[0]));
  pushbutton_debounce #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS), .ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .reset_n(reset_n), .button_raw(raw_n), .btn_level(lvl[1]),
    .press_pulse(pp[1]), .release_pulse(rp[1]), .glitch_count(gc[1]));
  always @(negedge clk) if (reset_n && (|pp || |rp)) begin
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL pulse_unexpected cyc=%0d press=%b release=%b level=%b, required no pulse", cyc, pp, rp, lvl);
    end else begin
      e = exp_q.pop_front();
      if (pp !== {2{e.press}} || rp !== {2{!e.press}} || lvl !== {2{e.press}} || cyc !== e.at) begin
        bad++;
        $display("FAIL pulse cyc=%0d press=%b release=%b level=%b, required cyc=%0d press=%b release=%b level=%b",
                 cyc, pp, rp, lvl, e.at, {2{e.press}}, {2{!e.press}}, {2{e.press}});
      end
    end
  end
  task automatic test_reset();
    exp_q.delete();
    exp_gc = 0;
    raw = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({lvl, pp, rp, gc[0], gc[1]} !== 22'd0) begin
      bad++;
      $display("FAIL reset_hold level=%b press=%b release=%b gc=%0d/%0d, required all 0", lvl, pp, rp, gc[0], gc[1]);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      total++;
      if ({lvl, pp, rp, gc[0], gc[1]} !== 22'd0) begin
        bad++;
        $display("FAIL reset_idle i=%0d level=%b press=%b release=%b gc=%0d/%0d, required all 0", i, lvl, pp, rp, gc[0], gc[1]);
      end
    end
  endtask
  task automatic finish_window(input string name, input logic [1:0] want_lvl);
    repeat (20) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_pending outstanding=%0d, required 0", name, exp_q.size());
      exp_q.delete();
    end
    total++;
    if (lvl !== want_lvl || gc[0] !== 8'(exp_gc) || gc[1] !== 8'(exp_gc)) begin
      bad++;
      $display("FAIL %s_state level=%b gc=%0d/%0d, required level=%b gc=%0d", name, lvl, gc[0], gc[1], want_lvl, exp_gc);
    end
  endtask
  task automatic test_clean_press();
    @(negedge clk);
    raw = 1'b0;
    exp_q.push_back('{press: 1'b1, at: cyc + LAT});
    finish_window("clean_press", 2'b11);
  endtask
  task automatic test_release();
    @(negedge clk);
    raw = 1'b1;
    exp_q.push_back('{press: 1'b0, at: cyc + LAT});
    finish_window("release", 2'b00);
  endtask
  task automatic test_bounce();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      raw = 1'b0;
      repeat (3) @(negedge clk);
      raw = 1'b1;
      repeat (2) @(negedge clk);
    end
    raw = 1'b0;
    exp_gc += 2;
    exp_q.push_back('{press: 1'b1, at: cyc + LAT});
    finish_window("bounce", 2'b11);
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    raw = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    exp_gc = 0;
    #1;
    total++;
    if ({lvl, pp, rp, gc[0], gc[1]} !== 22'd0) begin
      bad++;
      $display("FAIL reset_mid_async level=%b press=%b release=%b gc=%0d/%0d, required all 0", lvl, pp, rp, gc[0], gc[1]);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back('{press: 1'b1, at: cyc + LAT});
    finish_window("reset_mid", 2'b11);
  endtask
  task automatic glitches(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      raw = 1'b0;
      @(negedge clk);
      raw = 1'b1;
      repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask
  task automatic test_saturation();
    int steps [3] = '{10, 245, 45};
    int want  [3] = '{10, 255, 255};
    foreach (steps[j]) begin
      glitches(steps[j]);
      total++;
      if (gc[0] !== 8'(want[j]) || gc[1] !== 8'(want[j]) || lvl !== 2'b00) begin
        bad++;
        $display("FAIL saturation_%0d gc=%0d/%0d level=%b, required gc=%0d level=00", j, gc[0], gc[1], lvl, want[j]);
      end
    end
    exp_gc = 255;
  endtask
  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_release();
    test_reset_mid();
    test_release();
    test_saturation();
    test_reset();
    test_clean_press();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
